// File: rtl/ptt_pkg.sv
// Shared PTT definitions: one-hot state encodings, default debounce/timeout
// values and the state-to-output decode used by the conditioner and sequencers.
package ptt_pkg;

    localparam int DEB_CNT_DEF      = 4;
    localparam int TOT_CNT_DEF      = 20;
    localparam int TOT_CNT_SIZE_DEF = 21;

    localparam logic [3:0] S_IDLE    = 4'b0001;
    localparam logic [3:0] S_TX      = 4'b0010;
    localparam logic [3:0] S_TOTLOCK = 4'b0100;
    localparam logic [3:0] S_FAULT   = 4'b1000;

    typedef struct packed {
        logic ptt_out;
        logic tot_flag;
        logic fault_flag;
    } ptt_out_t;

    // ptt_out is active low: only TX pulls it down.
    function automatic ptt_out_t state_outputs(input logic [3:0] st);
        ptt_out_t o;
        o = '{ptt_out: 1'b1, tot_flag: 1'b0, fault_flag: 1'b0};
        case (st)
            S_TX:      o.ptt_out    = 1'b0;
            S_TOTLOCK: o.tot_flag   = 1'b1;
            S_FAULT:   o.fault_flag = 1'b1;
            default:   o.ptt_out    = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ptt_cond_if.sv
// Rig-side inputs and conditioned outputs of the PTT conditioner.
interface ptt_cond_if;
    logic ptt_raw;
    logic swr_fault;
    logic ptt_out;
    logic tot_flag;
    logic fault_flag;

    modport master (
        output ptt_raw,
        output swr_fault,
        input  ptt_out,
        input  tot_flag,
        input  fault_flag
    );

    modport slave (
        input  ptt_raw,
        input  swr_fault,
        output ptt_out,
        output tot_flag,
        output fault_flag
    );
endinterface

// File: rtl/ptt_cond_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for the
// active-low PTT line; idles (and resets) to the released level 1.
module ptt_debounce
    import ptt_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    logic [1:0]    r_sync;
    logic          r_db;
    logic [CW-1:0] r_cnt;
    logic          w_s;

    assign w_s  = r_sync[1];
    assign dout = r_db;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b11;
            r_db   <= 1'b1;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], din};
            // Any agreeing sample restarts the run, so short glitches never land.
            if (w_s == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_db  <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ptt_cond.sv
// PTT conditioner: debounced PTT, synchronized SWR fault, transmit timeout
// lockout and registered active-low PTT to the downstream sequencer.
module ptt_cond
    import ptt_pkg::*;
#(
    parameter int DEB_CNT      = DEB_CNT_DEF,
    parameter int TOT_CNT      = TOT_CNT_DEF,
    parameter int TOT_CNT_SIZE = TOT_CNT_SIZE_DEF
) (
    input  logic     clk,
    input  logic     reset,
    ptt_cond_if.slave ptt_if
);

    localparam logic                    TOT_EN   = (TOT_CNT != 0);
    localparam logic [TOT_CNT_SIZE-1:0] TOT_LOAD = TOT_CNT_SIZE'(TOT_CNT);

    logic                    w_ptt_db;
    logic                    w_fault_s;
    logic [1:0]              r_fsync;
    logic [3:0]              r_state;
    logic [3:0]              w_state_next;
    logic [TOT_CNT_SIZE-1:0] r_tot;
    ptt_out_t                r_out;
    ptt_out_t                w_out_next;

    ptt_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (ptt_if.ptt_raw),
        .dout  (w_ptt_db)
    );

    // The fault path is only synchronized: a trip must reach the PA immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsync <= 2'b00;
        end else begin
            r_fsync <= {r_fsync[0], ptt_if.swr_fault};
        end
    end

    assign w_fault_s = r_fsync[1];

    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (!w_fault_s && !w_ptt_db) begin
                    w_state_next = S_TX;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_TX: begin
                if (w_fault_s) begin
                    w_state_next = S_FAULT;
                end else if (w_ptt_db) begin
                    w_state_next = S_IDLE;
                end else if (TOT_EN && (r_tot == '0)) begin
                    w_state_next = S_TOTLOCK;
                end else begin
                    w_state_next = S_TX;
                end
            end
            // Lockouts only clear once the operator lets go of PTT.
            S_TOTLOCK: begin
                w_state_next = w_ptt_db ? S_IDLE : S_TOTLOCK;
            end
            S_FAULT: begin
                w_state_next = (w_ptt_db && !w_fault_s) ? S_IDLE : S_FAULT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_out_next = state_outputs(w_state_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tot   <= '0;
            r_out   <= '{ptt_out: 1'b1, tot_flag: 1'b0, fault_flag: 1'b0};
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            if ((r_state == S_IDLE) && (w_state_next == S_TX)) begin
                r_tot <= TOT_LOAD;
            end else if ((r_state == S_TX) && (r_tot != '0)) begin
                r_tot <= r_tot - TOT_CNT_SIZE'(1);
            end
        end
    end

    assign ptt_if.ptt_out    = r_out.ptt_out;
    assign ptt_if.tot_flag   = r_out.tot_flag;
    assign ptt_if.fault_flag = r_out.fault_flag;

endmodule

// File: tb/tb_ptt_cond.sv
// Scenario bench for ptt_cond (DEB_CNT=4, TOT_CNT=20): each scenario queues the
// expected {ptt_out, tot_flag, fault_flag} per edge and checks it after the edge.
module tb_ptt_cond;
    import ptt_pkg::*;

    typedef struct packed {
        logic ptt;
        logic tot;
        logic flt;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    ptt_cond_if ifc();

    ptt_cond #(
        .DEB_CNT      (4),
        .TOT_CNT      (20),
        .TOT_CNT_SIZE (21)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ptt_if (ifc)
    );

    always #5 clk = ~clk;

    // Apply inputs, let one edge sample them, then settle past the edge.
    task automatic step(input logic raw, input logic flt);
        ifc.ptt_raw   = raw;
        ifc.swr_fault = flt;
        @(posedge clk);
        #1;
    endtask

    function automatic logic inr(input int k, input int a, input int b);
        return (k >= a) && (k <= b);
    endfunction

    function automatic exp_t mk(input logic p, input logic t, input logic f);
        exp_t e;
        e.ptt = p;
        e.tot = t;
        e.flt = f;
        return e;
    endfunction

    task automatic test_reset();
        exp_t e, got;
        int   nf = n_fail;
        for (int k = 1; k <= 6; k++) begin
            reset = (k <= 3);
            sb_q.push_back(mk(1'b1, 1'b0, 1'b0));
            step((k <= 3) ? 1'b0 : 1'b1, (k <= 3) ? 1'b1 : 1'b0);
            e   = sb_q.pop_front();
            got = {ifc.ptt_out, ifc.tot_flag, ifc.fault_flag};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset k=%0d got=%b exp=%b", k, got, e);
            end
        end
        reset = 1'b0;
        $display("test_reset: %0d new failures", n_fail - nf);
    endtask

    task automatic test_key_latency();
        exp_t e, got;
        int   nf = n_fail;
        for (int k = 1; k <= 20; k++) begin
            sb_q.push_back(mk(!inr(k, 7, 16), 1'b0, 1'b0));
            step(!inr(k, 1, 10), 1'b0);
            e   = sb_q.pop_front();
            got = {ifc.ptt_out, ifc.tot_flag, ifc.fault_flag};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL key_latency k=%0d got=%b exp=%b", k, got, e);
            end
        end
        $display("test_key_latency: %0d new failures", n_fail - nf);
    endtask

    task automatic test_glitch();
        exp_t e, got;
        int   nf = n_fail;
        for (int k = 1; k <= 30; k++) begin
            sb_q.push_back(mk(!inr(k, 21, 24), 1'b0, 1'b0));
            step(!(inr(k, 1, 3) || inr(k, 15, 18)), 1'b0);
            e   = sb_q.pop_front();
            got = {ifc.ptt_out, ifc.tot_flag, ifc.fault_flag};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL glitch k=%0d got=%b exp=%b", k, got, e);
            end
        end
        $display("test_glitch: %0d new failures", n_fail - nf);
    endtask

    task automatic test_timeout();
        exp_t e, got;
        int   nf = n_fail;
        for (int k = 1; k <= 52; k++) begin
            sb_q.push_back(mk(!inr(k, 7, 27), inr(k, 28, 46), 1'b0));
            step(!inr(k, 1, 40), 1'b0);
            e   = sb_q.pop_front();
            got = {ifc.ptt_out, ifc.tot_flag, ifc.fault_flag};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL timeout k=%0d got=%b exp=%b", k, got, e);
            end
        end
        $display("test_timeout: %0d new failures", n_fail - nf);
    endtask

    task automatic test_fault_in_tx();
        exp_t e, got;
        int   nf = n_fail;
        for (int k = 1; k <= 40; k++) begin
            sb_q.push_back(mk(!inr(k, 7, 13), 1'b0, inr(k, 14, 35)));
            step(!inr(k, 1, 29), inr(k, 12, 20));
            e   = sb_q.pop_front();
            got = {ifc.ptt_out, ifc.tot_flag, ifc.fault_flag};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL fault_in_tx k=%0d got=%b exp=%b", k, got, e);
            end
        end
        $display("test_fault_in_tx: %0d new failures", n_fail - nf);
    endtask

    task automatic test_fault_holds_idle();
        exp_t e, got;
        int   nf = n_fail;
        for (int k = 1; k <= 40; k++) begin
            sb_q.push_back(mk(!inr(k, 23, 36), 1'b0, 1'b0));
            step(!inr(k, 3, 30), inr(k, 1, 20));
            e   = sb_q.pop_front();
            got = {ifc.ptt_out, ifc.tot_flag, ifc.fault_flag};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL fault_holds_idle k=%0d got=%b exp=%b", k, got, e);
            end
        end
        $display("test_fault_holds_idle: %0d new failures", n_fail - nf);
    endtask

    task automatic test_simultaneous();
        exp_t e, got;
        int   nf = n_fail;
        for (int k = 1; k <= 24; k++) begin
            sb_q.push_back(mk(!inr(k, 7, 15), 1'b0, inr(k, 16, 18)));
            step(!inr(k, 1, 9), inr(k, 14, 16));
            e   = sb_q.pop_front();
            got = {ifc.ptt_out, ifc.tot_flag, ifc.fault_flag};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL simultaneous k=%0d got=%b exp=%b", k, got, e);
            end
        end
        $display("test_simultaneous: %0d new failures", n_fail - nf);
    endtask

    task automatic test_reset_mid_tx();
        exp_t e, got;
        int   nf = n_fail;
        for (int k = 1; k <= 40; k++) begin
            reset = (k == 10);
            sb_q.push_back(mk(!(inr(k, 7, 9) || inr(k, 17, 34)), 1'b0, 1'b0));
            step(!inr(k, 1, 28), 1'b0);
            e   = sb_q.pop_front();
            got = {ifc.ptt_out, ifc.tot_flag, ifc.fault_flag};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_mid_tx k=%0d got=%b exp=%b", k, got, e);
            end
        end
        reset = 1'b0;
        $display("test_reset_mid_tx: %0d new failures", n_fail - nf);
    endtask

    task automatic test_back_to_back();
        exp_t e, got;
        int   nf = n_fail;
        for (int k = 1; k <= 34; k++) begin
            sb_q.push_back(mk(!(inr(k, 7, 14) || inr(k, 23, 30)), 1'b0, 1'b0));
            step(!(inr(k, 1, 8) || inr(k, 17, 24)), 1'b0);
            e   = sb_q.pop_front();
            got = {ifc.ptt_out, ifc.tot_flag, ifc.fault_flag};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d got=%b exp=%b", k, got, e);
            end
        end
        $display("test_back_to_back: %0d new failures", n_fail - nf);
    endtask

    initial begin
        ifc.ptt_raw   = 1'b1;
        ifc.swr_fault = 1'b0;
        test_reset();
        test_key_latency();
        test_glitch();
        test_timeout();
        test_key_latency();
        test_fault_in_tx();
        test_fault_holds_idle();
        test_simultaneous();
        test_reset_mid_tx();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
